// File: rtl/uart_pkg.sv
// Shared UART transmit types: FSM state encoding and parity-type constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TICK = 3'd1,
    START_BIT = 3'd2,
    DATA      = 3'd3,
    PARITY    = 3'd4,
    STOP      = 3'd5
  } tx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity of one data word: XOR reduction, inverted for odd parity.
module uart_parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  parity
);

  assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_cmd_burst_tx.sv
// Buffered UART transmitter: frames are queued while idle, then a single
// START sends every buffered frame back-to-back, paced by TICK_EN.
module uart_cmd_burst_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_FRAMES = 4
) (
  input  logic                            UART_CLK,
  input  logic                            RST,
  input  logic                            TICK_EN,
  input  logic                            WR_EN,
  input  logic [DATA_WIDTH-1:0]           WR_DATA,
  input  logic                            START,
  input  logic                            PAR_EN,
  input  logic                            PAR_TYP,
  output logic                            TX_OUT,
  output logic                            BUSY,
  output logic                            DONE,
  output logic                            FULL,
  output logic [$clog2(MAX_FRAMES+1)-1:0] COUNT
);

  localparam int CW = $clog2(MAX_FRAMES + 1);
  localparam int IW = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  tx_state_t             state, state_nx;
  logic [DATA_WIDTH-1:0] buf_mem [MAX_FRAMES];
  logic [CW-1:0]         count;
  logic [IW-1:0]         rd_idx;
  logic [BW-1:0]         bit_cnt;
  logic                  par_en_q, par_typ_q, done_q;
  logic                  start_acc, wr_acc, last_bit, last_frame, par_bit, tx_bit;
  logic [DATA_WIDTH-1:0] cur_data;

  assign BUSY  = (state != IDLE);
  assign FULL  = (count == CW'(MAX_FRAMES));
  assign COUNT = count;
  assign DONE  = done_q;
  // Line is driven straight from registered state so reset forces idle-high at once.
  assign TX_OUT = tx_bit;

  // START wins over a same-cycle write; writes are only taken while idle.
  assign start_acc = START && !BUSY && (count != '0);
  assign wr_acc    = WR_EN && !BUSY && !FULL && !start_acc;

  assign cur_data   = buf_mem[rd_idx];
  assign last_bit   = (bit_cnt == BW'(DATA_WIDTH - 1));
  assign last_frame = ((CW'(rd_idx) + CW'(1)) == count);

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data    (cur_data),
    .par_typ (par_typ_q),
    .parity  (par_bit)
  );

  // State register.
  always_ff @(posedge UART_CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state: one bit per tick once the burst has synchronised to the first tick.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (start_acc) state_nx = WAIT_TICK;
      WAIT_TICK: if (TICK_EN) state_nx = START_BIT;
      START_BIT: if (TICK_EN) state_nx = DATA;
      DATA:      if (TICK_EN && last_bit) state_nx = par_en_q ? PARITY : STOP;
      PARITY:    if (TICK_EN) state_nx = STOP;
      STOP:      if (TICK_EN) state_nx = last_frame ? IDLE : START_BIT;
      default:   state_nx = IDLE;
    endcase
  end

  // Serial line value for the current bit slot.
  always_comb begin
    tx_bit = 1'b1;
    case (state)
      START_BIT: tx_bit = 1'b0;
      DATA:      tx_bit = cur_data[bit_cnt];
      PARITY:    tx_bit = par_bit;
      default:   tx_bit = 1'b1;
    endcase
  end

  // Frame counter, read index, bit counter, latched parity config and DONE pulse.
  always_ff @(posedge UART_CLK or posedge RST) begin
    if (RST) begin
      count     <= '0;
      rd_idx    <= '0;
      bit_cnt   <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wr_acc) count <= count + CW'(1);
      if (start_acc) begin
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
        rd_idx    <= '0;
      end
      if (TICK_EN) begin
        case (state)
          START_BIT: bit_cnt <= '0;
          DATA:      bit_cnt <= bit_cnt + BW'(1);
          STOP: begin
            if (last_frame) begin
              count  <= '0;
              rd_idx <= '0;
              done_q <= 1'b1;
            end else begin
              rd_idx <= rd_idx + IW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Frame storage; the write slot is the current fill level.
  always_ff @(posedge UART_CLK) begin
    if (wr_acc) buf_mem[count[IW-1:0]] <= WR_DATA;
  end

endmodule

// File: tb/tb_uart_cmd_burst_tx.sv
// Randomised scoreboard bench for the burst UART transmitter.
module tb_uart_cmd_burst_tx;

  localparam int DW = 8;
  localparam int MF = 4;

  logic          UART_CLK = 1'b0;
  logic          RST, TICK_EN, WR_EN, START, PAR_EN, PAR_TYP;
  logic [DW-1:0] WR_DATA;
  logic          TX_OUT, BUSY, DONE, FULL;
  logic [2:0]    COUNT;

  int         checks   = 0;
  int         failures = 0;
  bit         exp_bits[$];
  int         exp_done = 0;
  logic [7:0] m_buf[$];
  bit         m_busy   = 1'b0;
  bit         tick_on  = 1'b0;

  uart_cmd_burst_tx #(.DATA_WIDTH(DW), .MAX_FRAMES(MF)) dut (
    .UART_CLK (UART_CLK),
    .RST      (RST),
    .TICK_EN  (TICK_EN),
    .WR_EN    (WR_EN),
    .WR_DATA  (WR_DATA),
    .START    (START),
    .PAR_EN   (PAR_EN),
    .PAR_TYP  (PAR_TYP),
    .TX_OUT   (TX_OUT),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .FULL     (FULL),
    .COUNT    (COUNT)
  );

  always #5 UART_CLK = ~UART_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge UART_CLK);
    #1;
  endtask

  // Reference frame: start 0, data LSB first, optional parity, stop 1.
  task automatic add_frame(input logic [7:0] b, input bit pe, input bit pt);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) exp_bits.push_back(b[i]);
    if (pe) exp_bits.push_back((^b) ^ pt);
    exp_bits.push_back(1'b1);
  endtask

  task automatic push(input logic [7:0] b);
    WR_EN   = 1'b1;
    WR_DATA = b;
    if (!m_busy && m_buf.size() < MF) m_buf.push_back(b);
    step();
    WR_EN = 1'b0;
    if (!m_busy) begin
      chk("count_after_push", COUNT, m_buf.size());
      chk("full_after_push", FULL, m_buf.size() == MF);
    end
  endtask

  task automatic start_burst(input bit pe, input bit pt, input bit with_wr, input logic [7:0] wb);
    START   = 1'b1;
    PAR_EN  = pe;
    PAR_TYP = pt;
    if (with_wr) begin
      WR_EN   = 1'b1;
      WR_DATA = wb;
    end
    if (!m_busy && m_buf.size() > 0) begin
      exp_bits.push_back(1'b1);  // line stays idle until the first tick
      foreach (m_buf[i]) add_frame(m_buf[i], pe, pt);
      exp_done++;
      m_buf.delete();
      m_busy = 1'b1;
    end else if (with_wr && !m_busy && m_buf.size() < MF) begin
      m_buf.push_back(wb);
    end
    step();
    START   = 1'b0;
    WR_EN   = 1'b0;
    PAR_EN  = 1'($urandom);
    PAR_TYP = 1'($urandom);
    chk("busy_after_start", BUSY, m_busy);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 4000; i++) begin
      @(negedge UART_CLK);
      if (!BUSY) break;
    end
    chk("burst_end_in_time", BUSY, 0);
    @(negedge UART_CLK);
    chk("done_seen", exp_done, 0);
    m_busy = 1'b0;
    chk("count_after_burst", COUNT, m_buf.size());
  endtask

  // Random bit-period strobe.
  initial begin
    TICK_EN = 1'b0;
    forever begin
      @(posedge UART_CLK);
      #1;
      TICK_EN = tick_on && ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor: every tick during a burst presents one line bit; DONE closes a burst.
  initial begin
    forever begin
      @(negedge UART_CLK);
      if (!RST) begin
        if (BUSY && TICK_EN) begin
          if (exp_bits.size() == 0) chk("extra_line_bit", 1, 0);
          else chk("tx_bit", TX_OUT, exp_bits.pop_front());
        end
        if (!BUSY) chk("tx_idle_high", TX_OUT, 1);
        if (DONE) begin
          if (exp_done == 0) chk("unexpected_done", 1, 0);
          else begin
            exp_done--;
            chk("bits_left_at_done", exp_bits.size(), 0);
          end
        end
      end
    end
  end

  initial begin
    int tgt;
    int nfr;
    RST = 1'b1; WR_EN = 1'b0; START = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; WR_DATA = '0;
    tick_on = 1'b1;
    repeat (3) step();
    chk("rst_tx", TX_OUT, 1);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_count", COUNT, 0);
    chk("rst_full", FULL, 0);
    RST = 1'b0;
    step();

    // Three frames with even parity.
    push(8'hAA); push(8'h05); push(8'h77);
    start_burst(1'b1, 1'b0, 1'b0, 8'h00);
    wait_idle();

    // Odd parity, then no parity.
    push(8'hDD);
    start_burst(1'b1, 1'b1, 1'b0, 8'h00);
    wait_idle();
    push(8'hDD);
    start_burst(1'b0, 1'b0, 1'b0, 8'h00);
    wait_idle();

    // Overfill: fifth push is dropped.
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    chk("full_count", COUNT, MF);
    chk("full_flag", FULL, 1);
    start_burst(1'b1, 1'b0, 1'b0, 8'h00);
    wait_idle();

    // START with an empty buffer is ignored.
    start_burst(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (20) step();
    chk("empty_start_busy", BUSY, 0);

    // START and writes during a burst are ignored.
    push(8'h3C); push(8'hC3);
    start_burst(1'b1, 1'b1, 1'b0, 8'h00);
    repeat (5) step();
    start_burst(1'b0, 1'b0, 1'b0, 8'h00);
    push(8'h99);
    wait_idle();

    // START and WR_EN together: write dropped.
    push(8'h5A);
    start_burst(1'b0, 1'b1, 1'b1, 8'hE7);
    wait_idle();

    // Reset during the data bits of frame 2.
    push(8'hF0); push(8'h0F); push(8'hA5);
    start_burst(1'b1, 1'b0, 1'b0, 8'h00);
    tgt = exp_bits.size() - 15;
    for (int i = 0; i < 3000; i++) begin
      @(negedge UART_CLK);
      if (exp_bits.size() <= tgt) break;
    end
    chk("reached_frame2", exp_bits.size() <= tgt, 1);
    #2;
    RST = 1'b1;
    exp_bits.delete();
    exp_done = 0;
    m_buf.delete();
    m_busy = 1'b0;
    #1;
    chk("midrst_tx", TX_OUT, 1);
    chk("midrst_busy", BUSY, 0);
    chk("midrst_count", COUNT, 0);
    chk("midrst_done", DONE, 0);
    repeat (3) step();
    RST = 1'b0;
    repeat (100) step();

    // Randomised bursts.
    for (int it = 0; it < 8; it++) begin
      nfr = $urandom_range(1, 5);
      for (int k = 0; k < nfr; k++) push(8'($urandom));
      start_burst(1'($urandom), 1'($urandom), 1'b0, 8'h00);
      if ($urandom_range(0, 1) == 1) push(8'($urandom));
      wait_idle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
